// File: rtl/light_scheduler.sv
// Colour auto-cycle sequencer for the RGB light path: steps the six coded colours
// with a programmable dwell, pauses/resumes on button edges, and shows white when idle.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | white output, converter disabled, waiting for start
// ST_RUN   | colour held for dwell_r cycles, then advances 1..6 and wraps
// ST_PAUSE | colour and dwell counter frozen, converter still enabled
module light_scheduler #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               button,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         colour,
    output logic               sel,
    output logic               enable,
    output logic               busy,
    output logic               wrap
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] counter_q, counter_d;
    logic [DWELL_W-1:0] dwell_r_q, dwell_r_d;
    logic               button_q, button_d;
    logic [2:0]         colour_q, colour_d;
    logic               sel_q, sel_d;
    logic               enable_q, enable_d;
    logic               busy_q, busy_d;
    logic               wrap_q, wrap_d;

    logic               btn_edge;
    logic               at_term;
    logic [2:0]         tick_colour;
    logic [DWELL_W-1:0] tick_counter;
    logic               tick_wrap;
    logic [DWELL_W-1:0] dwell_eff;

    // One counted RUN cycle: either advance the colour or bump the counter.
    always_comb begin
        btn_edge     = button & ~button_q;
        at_term      = (counter_q == (dwell_r_q - {{(DWELL_W-1){1'b0}}, 1'b1}));
        dwell_eff    = (dwell == '0) ? {{(DWELL_W-1){1'b0}}, 1'b1} : dwell;
        tick_colour  = colour_q;
        tick_counter = counter_q + {{(DWELL_W-1){1'b0}}, 1'b1};
        tick_wrap    = 1'b0;
        if (at_term) begin
            tick_counter = '0;
            tick_colour  = (colour_q == 3'd6) ? 3'd1 : colour_q + 3'd1;
            tick_wrap    = (colour_q == 3'd6);
        end
    end

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        dwell_r_d = dwell_r_q;
        button_d  = button;
        colour_d  = colour_q;
        wrap_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                colour_d  = 3'd0;
                counter_d = '0;
                if (!stop && start) begin
                    state_d   = ST_RUN;
                    colour_d  = 3'd1;
                    dwell_r_d = dwell_eff;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d   = ST_IDLE;
                    colour_d  = 3'd0;
                    counter_d = '0;
                end else if (btn_edge) begin
                    state_d = ST_PAUSE;
                end else begin
                    colour_d  = tick_colour;
                    counter_d = tick_counter;
                    wrap_d    = tick_wrap;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_d   = ST_IDLE;
                    colour_d  = 3'd0;
                    counter_d = '0;
                end else if (btn_edge) begin
                    // The resume edge is itself the first counted RUN cycle.
                    state_d   = ST_RUN;
                    colour_d  = tick_colour;
                    counter_d = tick_counter;
                    wrap_d    = tick_wrap;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                colour_d  = 3'd0;
                counter_d = '0;
            end
        endcase

        busy_d   = (state_d != ST_IDLE);
        sel_d    = busy_d;
        enable_d = busy_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            counter_q <= '0;
            dwell_r_q <= {{(DWELL_W-1){1'b0}}, 1'b1};
            button_q  <= 1'b0;
            colour_q  <= 3'd0;
            sel_q     <= 1'b0;
            enable_q  <= 1'b0;
            busy_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            dwell_r_q <= dwell_r_d;
            button_q  <= button_d;
            colour_q  <= colour_d;
            sel_q     <= sel_d;
            enable_q  <= enable_d;
            busy_q    <= busy_d;
            wrap_q    <= wrap_d;
        end
    end

    assign colour = colour_q;
    assign sel    = sel_q;
    assign enable = enable_q;
    assign busy   = busy_q;
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_light_scheduler.sv
// Bench for light_scheduler: a cycle model pushes expected outputs to a queue as each
// input vector is driven; the queue is popped and compared after every clock edge.
module tb_light_scheduler;

    logic        clk = 1'b0;
    logic        rst, start, stop, button;
    logic [15:0] dwell;
    logic [2:0]  colour;
    logic        sel, enable, busy, wrap;

    light_scheduler #(.DWELL_W(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .stop   (stop),
        .button (button),
        .dwell  (dwell),
        .colour (colour),
        .sel    (sel),
        .enable (enable),
        .busy   (busy),
        .wrap   (wrap)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [6:0] exp_q[$];

    // Reference model: 0 idle, 1 run, 2 pause; m_rem = cycles left on the current colour.
    int m_state = 0;
    int m_colour = 0;
    int m_rem = 1;
    int m_dw = 1;
    bit m_btn = 1'b0;
    bit m_wrap = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_tick();
        if (m_rem == 1) begin
            m_wrap   = (m_colour == 6);
            m_colour = (m_colour == 6) ? 1 : m_colour + 1;
            m_rem    = m_dw;
        end else begin
            m_rem = m_rem - 1;
        end
    endtask

    task automatic model_step();
        bit edge_s;
        edge_s = button && !m_btn;
        m_btn  = button;
        m_wrap = 1'b0;
        if (rst) begin
            m_state = 0; m_colour = 0; m_dw = 1; m_btn = 1'b0;
        end else if (stop) begin
            m_state = 0; m_colour = 0;
        end else if (m_state == 0) begin
            if (start) begin
                m_state = 1; m_colour = 1;
                m_dw = (dwell == 0) ? 1 : int'(dwell);
                m_rem = m_dw;
            end
        end else if (m_state == 1) begin
            if (edge_s) m_state = 2;
            else model_tick();
        end else if (edge_s) begin
            m_state = 1;
            model_tick();
        end
    endtask

    task automatic step();
        logic [6:0] e;
        bit b;
        model_step();
        b = (m_state != 0);
        exp_q.push_back({3'(m_colour), b, b, b, m_wrap});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq("sb_underflow", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check_eq("colour", 32'(colour), 32'(e[6:4]));
            check_eq("busy_sel_en_wrap", 32'({busy, sel, enable, wrap}), 32'(e[3:0]));
        end
        check_eq("inv_colour_range", 32'(busy && (colour == 3'd0 || colour == 3'd7)), 0);
        check_eq("inv_sel_en_busy", 32'({sel, enable}), 32'({busy, busy}));
    endtask

    initial begin
        int wrap_at, cnt;
        logic [2:0] prev;
        rst = 1'b1; start = 1'b0; stop = 1'b0; button = 1'b0; dwell = 16'd0;
        step(); step();
        check_eq("reset_outputs", 32'({colour, sel, enable, busy, wrap}), 0);
        rst = 1'b0;

        // Auto-cycle with dwell 3: wrap 18 cycles after entry to colour 1
        dwell = 16'd3; start = 1'b1; step(); start = 1'b0;
        check_eq("start_latency", 32'({colour, busy}), 32'({3'd1, 1'b1}));
        wrap_at = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (wrap && wrap_at < 0) wrap_at = k;
        end
        check_eq("wrap_latency", wrap_at, 18);

        // Reset mid-sequence at colour 4, with other inputs active
        for (int k = 0; k < 30 && colour != 3'd4; k++) step();
        check_eq("reach_colour4", 32'(colour), 4);
        rst = 1'b1; start = 1'b1; button = 1'b1; step();
        check_eq("rst_midrun", 32'({colour, sel, enable, busy, wrap}), 0);
        rst = 1'b0; start = 1'b0; button = 1'b0; step();

        // Dwell 0 behaves as 1; a later dwell change is ignored until restart
        dwell = 16'd0; start = 1'b1; step(); start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            prev = colour;
            step();
            check_eq("dwell0_advance", 32'(colour), (prev == 3'd6) ? 1 : 32'(prev) + 1);
        end
        dwell = 16'd5;
        for (int k = 0; k < 4; k++) begin
            prev = colour;
            step();
            check_eq("dwell_not_relatched", 32'(colour), (prev == 3'd6) ? 1 : 32'(prev) + 1);
        end
        stop = 1'b1; step(); stop = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        cnt = 1;
        for (int k = 0; k < 8 && colour == 3'd1; k++) begin
            step();
            if (colour == 3'd1) cnt++;
        end
        check_eq("dwell5_hold", cnt, 5);

        // Pause/resume with dwell 4: pause after 2 cycles of colour 2
        stop = 1'b1; step(); stop = 1'b0;
        dwell = 16'd4; start = 1'b1; step(); start = 1'b0;
        for (int k = 0; k < 10 && colour != 3'd2; k++) step();
        check_eq("reach_colour2", 32'(colour), 2);
        step();
        button = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (colour == 3'd2 && busy) cnt++;
        end
        check_eq("pause_hold", cnt, 10);
        button = 1'b0; step();
        button = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (colour == 3'd2) cnt++;
            else break;
        end
        check_eq("resume_remaining", cnt, 2);
        check_eq("after_resume_colour", 32'(colour), 3);
        button = 1'b0;

        // Advance coincident with button edge at colour 6: pause wins, no wrap
        stop = 1'b1; step(); stop = 1'b0;
        dwell = 16'd1; start = 1'b1; step(); start = 1'b0;
        for (int k = 0; k < 10 && colour != 3'd6; k++) step();
        check_eq("reach_colour6", 32'(colour), 6);
        button = 1'b1; step();
        check_eq("coll_colour", 32'(colour), 6);
        check_eq("coll_wrap", 32'(wrap), 0);
        step();
        check_eq("coll_paused", 32'({colour, busy}), 32'({3'd6, 1'b1}));

        // Stop together with a button edge goes to IDLE
        button = 1'b0; step();
        button = 1'b1; stop = 1'b1; step();
        check_eq("stop_with_edge", 32'({colour, busy}), 0);
        button = 1'b0; stop = 1'b0; step();

        // Start held during RUN does not restart or relatch
        dwell = 16'd3; start = 1'b1; step();
        dwell = 16'd7;
        cnt = 1;
        for (int k = 0; k < 10 && colour == 3'd1; k++) begin
            step();
            if (colour == 3'd1) cnt++;
        end
        check_eq("start_in_run", cnt, 3);
        start = 1'b0;

        // Stop and start together in IDLE stays idle
        stop = 1'b1; step();
        start = 1'b1; step();
        check_eq("stop_start_idle", 32'({colour, busy}), 0);
        stop = 1'b0; start = 1'b0; step(); step();

        check_eq("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
